// File: rtl/buffer_2_if.sv
// Handshake and data bundle between the sum stage, buffer_2 and the memory-write master.
interface buffer_2_if;
  logic [7:0]  i_processed_sum_1;
  logic [7:0]  i_processed_sum_2;
  logic [7:0]  i_processed_sum_3;
  logic [7:0]  i_processed_sum_4;
  logic [7:0]  i_processed_sum_5;
  logic [7:0]  i_processed_sum_6;
  logic [7:0]  i_processed_sum_7;
  logic [7:0]  i_processed_sum_8;
  logic [7:0]  i_processed_sum_9;
  logic        i_save;
  logic        i_write_complete;
  logic        o_empty;
  logic        o_full;
  logic [31:0] o_buffer2_data;
  logic        o_write_enable;

  // Producer / writer side: drives sums and handshakes, observes buffer status.
  modport master (
    output i_processed_sum_1, i_processed_sum_2, i_processed_sum_3,
    output i_processed_sum_4, i_processed_sum_5, i_processed_sum_6,
    output i_processed_sum_7, i_processed_sum_8, i_processed_sum_9,
    output i_save, i_write_complete,
    input  o_empty, o_full, o_buffer2_data, o_write_enable
  );

  // Buffer side.
  modport slave (
    input  i_processed_sum_1, i_processed_sum_2, i_processed_sum_3,
    input  i_processed_sum_4, i_processed_sum_5, i_processed_sum_6,
    input  i_processed_sum_7, i_processed_sum_8, i_processed_sum_9,
    input  i_save, i_write_complete,
    output o_empty, o_full, o_buffer2_data, o_write_enable
  );
endinterface

// File: rtl/buffer_2.sv
// Nine-entry output buffer: captures a 3x3 window in one cycle, then streams it out one pixel
// per write-complete as {p,p,p,alpha}. Define BUFFER2_ALPHA_OPAQUE_EN for alpha = 8'hFF.
module buffer_2 (
  input logic        clk,
  input logic        n_rst,
  buffer_2_if.slave  bus
);

  localparam int unsigned Depth = 9;

`ifdef BUFFER2_ALPHA_OPAQUE_EN
  localparam logic [7:0] Alpha = 8'hFF;
`else
  localparam logic [7:0] Alpha = 8'h00;
`endif

  logic [7:0]  sum_in [Depth];
  logic [7:0]  mem_q  [Depth];
  logic [7:0]  mem_d  [Depth];
  logic [3:0]  rd_idx_q, rd_idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  rd_idx_nxt;
  logic        save_go;
  logic        adv_go;

  assign sum_in[0] = bus.i_processed_sum_1;
  assign sum_in[1] = bus.i_processed_sum_2;
  assign sum_in[2] = bus.i_processed_sum_3;
  assign sum_in[3] = bus.i_processed_sum_4;
  assign sum_in[4] = bus.i_processed_sum_5;
  assign sum_in[5] = bus.i_processed_sum_6;
  assign sum_in[6] = bus.i_processed_sum_7;
  assign sum_in[7] = bus.i_processed_sum_8;
  assign sum_in[8] = bus.i_processed_sum_9;

  function automatic logic [31:0] replicate(input logic [7:0] p);
    return {p, p, p, Alpha};
  endfunction

  // Save only lands on an empty buffer, so it always wins over a simultaneous complete there.
  assign save_go    = bus.i_save && (cnt_q == 4'd0);
  assign adv_go     = bus.i_write_complete && (cnt_q != 4'd0);
  assign rd_idx_nxt = rd_idx_q + 4'd1;

  always_comb begin
    mem_d    = mem_q;
    rd_idx_d = rd_idx_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    if (save_go) begin
      mem_d    = sum_in;
      cnt_d    = 4'(Depth);
      rd_idx_d = 4'd0;
      data_d   = replicate(sum_in[0]);
    end else if (adv_go) begin
      cnt_d = cnt_q - 4'd1;
      // On the last pixel the word is left as-is so the writer still sees sum_9.
      if (cnt_q != 4'd1) begin
        rd_idx_d = rd_idx_nxt;
        data_d   = replicate(mem_q[rd_idx_nxt]);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= 8'h00;
      end
      rd_idx_q <= 4'd0;
      cnt_q    <= 4'd0;
      data_q   <= 32'h0;
    end else begin
      mem_q    <= mem_d;
      rd_idx_q <= rd_idx_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
    end
  end

  assign bus.o_buffer2_data = data_q;
  assign bus.o_empty        = (cnt_q == 4'd0);
  assign bus.o_full         = (cnt_q == 4'(Depth));
  assign bus.o_write_enable = (cnt_q != 4'd0);

`ifndef SYNTHESIS
  cnt_range_a : assert property (@(posedge clk) disable iff (!n_rst) cnt_q <= 4'(Depth));
  idx_range_a : assert property (@(posedge clk) disable iff (!n_rst) rd_idx_q < 4'(Depth));
`endif

endmodule

// File: tb/tb_buffer_2.sv
// Directed bench for buffer_2: load, drain, empty behaviour, ignored saves, collisions, resets.
module tb_buffer_2;

`ifdef BUFFER2_ALPHA_OPAQUE_EN
  localparam logic [7:0] ExpAlpha = 8'hFF;
`else
  localparam logic [7:0] ExpAlpha = 8'h00;
`endif

  logic clk;
  logic n_rst;
  int   checks;
  int   errors;

  buffer_2_if bif ();

  buffer_2 u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rep(input logic [7:0] p);
    return {p, p, p, ExpAlpha};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic e, input logic f, input logic w);
    check_val({tag, "_empty"}, 32'(bif.o_empty), 32'(e));
    check_val({tag, "_full"},  32'(bif.o_full),  32'(f));
    check_val({tag, "_we"},    32'(bif.o_write_enable), 32'(w));
  endtask

  task automatic set_sums(input logic [7:0] s [9]);
    bif.i_processed_sum_1 = s[0];
    bif.i_processed_sum_2 = s[1];
    bif.i_processed_sum_3 = s[2];
    bif.i_processed_sum_4 = s[3];
    bif.i_processed_sum_5 = s[4];
    bif.i_processed_sum_6 = s[5];
    bif.i_processed_sum_7 = s[6];
    bif.i_processed_sum_8 = s[7];
    bif.i_processed_sum_9 = s[8];
  endtask

  // Drive for exactly one rising edge; returns at the following falling edge.
  task automatic step(input logic save, input logic wc);
    @(negedge clk);
    bif.i_save           = save;
    bif.i_write_complete = wc;
    @(negedge clk);
    bif.i_save           = 1'b0;
    bif.i_write_complete = 1'b0;
  endtask

  task automatic reset_mid_cycle();
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check_val("rst_data", bif.o_buffer2_data, 32'h0);
    check_flags("rst", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  logic [7:0] sums_a [9];
  logic [7:0] sums_b [9];
  logic [7:0] sums_c [9];

  initial begin
    checks = 0;
    errors = 0;
    sums_a = '{8'd12, 8'd21, 8'd252, 8'd40, 8'd67, 8'd255, 8'd117, 8'd134, 8'd239};
    sums_b = '{8'd99, 8'd98, 8'd97, 8'd96, 8'd95, 8'd94, 8'd93, 8'd92, 8'd91};
    sums_c = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    bif.i_save           = 1'b0;
    bif.i_write_complete = 1'b0;
    set_sums(sums_b);
    n_rst = 1'b1;

    #12 n_rst = 1'b0;
    #1;
    check_val("init_rst_data", bif.o_buffer2_data, 32'h0);
    check_flags("init_rst", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;

    // Load and hold.
    set_sums(sums_a);
    step(1'b1, 1'b0);
    check_val("load_data", bif.o_buffer2_data, rep(8'd12));
    check_flags("load", 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("hold_data", bif.o_buffer2_data, rep(8'd12));
    end

    // Save while non-empty must not overwrite.
    set_sums(sums_b);
    step(1'b1, 1'b0);
    check_val("save_ign_data", bif.o_buffer2_data, rep(8'd12));
    check_flags("save_ign", 1'b0, 1'b1, 1'b1);

    // Drain eight pixels.
    for (int i = 1; i < 9; i++) begin
      step(1'b0, 1'b1);
      check_val($sformatf("drain%0d_data", i), bif.o_buffer2_data, rep(sums_a[i]));
      check_flags($sformatf("drain%0d", i), 1'b0, 1'b0, 1'b1);
      repeat (6) @(negedge clk);
    end

    // Ninth pulse empties; last pixel stays on the bus.
    step(1'b0, 1'b1);
    check_val("empty_data", bif.o_buffer2_data, rep(8'd239));
    check_flags("empty", 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check_val("empty_wc_data", bif.o_buffer2_data, rep(8'd239));
    check_flags("empty_wc", 1'b1, 1'b0, 1'b0);

    // Save and complete together while empty: save wins.
    set_sums(sums_c);
    step(1'b1, 1'b1);
    check_val("coll_empty_data", bif.o_buffer2_data, rep(8'd1));
    check_flags("coll_empty", 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1);
    check_val("after_coll_data", bif.o_buffer2_data, rep(8'd2));
    // Save and complete together while non-empty: complete wins.
    set_sums(sums_b);
    step(1'b1, 1'b1);
    check_val("coll_full_data", bif.o_buffer2_data, rep(8'd3));
    check_flags("coll_full", 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1);
    check_val("pre_rst_data", bif.o_buffer2_data, rep(8'd4));

    // Reset mid-drain, then restart from sum_1.
    reset_mid_cycle();
    @(negedge clk);
    check_flags("post_rst", 1'b1, 1'b0, 1'b0);
    set_sums(sums_a);
    step(1'b1, 1'b0);
    check_val("reload_data", bif.o_buffer2_data, rep(8'd12));
    check_flags("reload", 1'b0, 1'b1, 1'b1);

    // Complete held for three cycles consumes three pixels.
    @(negedge clk);
    bif.i_write_complete = 1'b1;
    repeat (3) @(negedge clk);
    bif.i_write_complete = 1'b0;
    check_val("held_data", bif.o_buffer2_data, rep(8'd40));
    check_flags("held", 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
